// File: rtl/dmem_lat.sv
// Data-memory model with configurable latency, byte strobes and a stall handshake.
// Optional address-error checking is enabled by defining DMEM_ERR_EN.
module dmem_lat #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ren,
  input  logic                i_wen,
  input  logic [AWIDTH-1:0]   i_addr,
  input  logic [DWIDTH-1:0]   i_wdata,
  input  logic [DWIDTH/8-1:0] i_wstrb,
  output logic [DWIDTH-1:0]   o_rdata,
  output logic                o_rvalid,
  output logic                o_stall,
  output logic                o_err
);

  localparam int unsigned NB  = DWIDTH / 8;
  localparam int unsigned OFS = $clog2(NB);
  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(LATENCY) + 1;

  logic          req_c;
  logic [IW-1:0] idx_c;
  logic          addr_err_c;

  assign req_c = i_ren | i_wen;
  assign idx_c = i_addr[OFS +: IW];

`ifdef DMEM_ERR_EN
  // Only the index field may be nonzero in a legal word-aligned address.
  localparam logic [AWIDTH-1:0] IDX_MASK = AWIDTH'(DEPTH - 1) << OFS;
  assign addr_err_c = |(i_addr & ~IDX_MASK);
`else
  logic unused_addr_c;
  assign addr_err_c    = 1'b0;
  assign unused_addr_c = ^i_addr;
`endif

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              mem_we_c;
  logic [IW-1:0]     mem_widx_c;
  logic [DWIDTH-1:0] mem_wdata_c;
  logic [NB-1:0]     mem_wstrb_c;

  // Storage is not reset; only strobed lanes are updated.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (mem_wstrb_c[k]) mem_q[mem_widx_c][8*k +: 8] <= mem_wdata_c[8*k +: 8];
      end
    end
  end

  if (LATENCY == 0) begin : gen_single
    logic unused_rst_c;
    assign unused_rst_c = rst;

    assign mem_we_c    = i_wen & ~addr_err_c;
    assign mem_widx_c  = idx_c;
    assign mem_wdata_c = i_wdata;
    assign mem_wstrb_c = i_wstrb;

    assign o_rdata  = addr_err_c ? '0 : mem_q[idx_c];
    assign o_rvalid = i_ren & ~i_wen;
    assign o_stall  = 1'b0;
    assign o_err    = req_c & addr_err_c;
  end else begin : gen_fsm
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic              wr_q, wr_d;
    logic              aerr_q, aerr_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic              done_next_c;

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wr_d        = wr_q;
      aerr_d      = aerr_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      err_d       = 1'b0;
      done_next_c = 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_c) begin
            idx_d   = idx_c;
            wdata_d = i_wdata;
            wstrb_d = i_wstrb;
            wr_d    = i_wen;
            aerr_d  = addr_err_c;
            cnt_d   = CW'(LATENCY - 1);
            if (LATENCY > 1) begin
              state_d = S_BUSY;
            end else begin
              state_d     = S_DONE;
              done_next_c = 1'b1;
            end
          end
        end
        S_BUSY: begin
          cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
          if (cnt_d == '0) begin
            state_d     = S_DONE;
            done_next_c = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      // Read data is captured on entry to DONE so it is a registered output there.
      if (done_next_c) begin
        err_d = aerr_d;
        if (!wr_d) begin
          rvalid_d = 1'b1;
          rdata_d  = aerr_d ? '0 : mem_q[idx_d];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        idx_q    <= '0;
        wdata_q  <= '0;
        wstrb_q  <= '0;
        wr_q     <= 1'b0;
        aerr_q   <= 1'b0;
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        idx_q    <= idx_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
        wr_q     <= wr_d;
        aerr_q   <= aerr_d;
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
        err_q    <= err_d;
      end
    end

    // Writes commit at the edge that ends DONE, so a reset before then drops them.
    assign mem_we_c    = (state_q == S_DONE) & wr_q & ~aerr_q;
    assign mem_widx_c  = idx_q;
    assign mem_wdata_c = wdata_q;
    assign mem_wstrb_c = wstrb_q;

    assign o_stall  = ((state_q == S_IDLE) & req_c) | (state_q == S_BUSY);
    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;
    assign o_err    = err_q;
  end

endmodule

// File: tb/tb_dmem_lat.sv
// Directed bench for dmem_lat: a LATENCY=2 instance and a single-cycle instance.
module tb_dmem_lat;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        rvalid, stall, err;

  logic        ren0 = 1'b0, wen0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  wstrb0 = '0;
  logic [31:0] rdata0;
  logic        rvalid0, stall0, err0;

  int n_chk = 0;
  int n_bad = 0;
  int stall0_hits = 0;

  dmem_lat #(.DWIDTH(32), .AWIDTH(32), .DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .i_ren(ren), .i_wen(wen), .i_addr(addr),
    .i_wdata(wdata), .i_wstrb(wstrb), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_stall(stall), .o_err(err)
  );

  dmem_lat #(.DWIDTH(32), .AWIDTH(32), .DEPTH(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_ren(ren0), .i_wen(wen0), .i_addr(addr0),
    .i_wdata(wdata0), .i_wstrb(wstrb0), .o_rdata(rdata0), .o_rvalid(rvalid0),
    .o_stall(stall0), .o_err(err0)
  );

  always @(negedge clk) if (stall0 !== 1'b0) stall0_hits++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present a request and hold it while stalled; return what the completion cycle shows.
  task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int stalls, output logic [31:0] rd,
                     output logic rv, output logic er);
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d; wstrb = s;
    #1;
    stalls = 0;
    while (stall === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd = rdata; rv = rvalid; er = err;
    @(posedge clk);
    #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int          st;
    logic [31:0] rd;
    logic        rv, er;

    repeat (2) @(negedge clk);
    check("rst_stall",  32'(stall),  32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata",  rdata,       32'd0);
    check("rst_err",    32'(err),    32'd0);
    rst = 1'b1;

    acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, st, rd, rv, er);
    check("wr10_stalls", 32'(st), 32'd2);
    check("wr10_rvalid", 32'(rv), 32'd0);
    check("wr10_err",    32'(er), 32'd0);

    acc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, st, rd, rv, er);
    check("rd10_stalls", 32'(st), 32'd2);
    check("rd10_rvalid", 32'(rv), 32'd1);
    check("rd10_rdata",  rd,      32'hDEADBEEF);
    check("rd10_pulse",  32'(rvalid), 32'd0);
    check("rd10_hold",   rdata,   32'hDEADBEEF);

    acc(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, st, rd, rv, er);
    acc(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, st, rd, rv, er);
    acc(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, st, rd, rv, er);
    check("strb_rdata",  rd,      32'h11BB33DD);
    check("strb_rvalid", 32'(rv), 32'd1);

    acc(1'b1, 1'b1, 32'h30, 32'h5, 4'hF, st, rd, rv, er);
    check("rw30_rvalid", 32'(rv), 32'd0);
    check("rw30_hold",   rd,      32'h11BB33DD);
    check("rw30_stalls", 32'(st), 32'd2);
    acc(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, st, rd, rv, er);
    check("rd30_rdata",  rd,      32'h5);

    // Reset during BUSY of a write must drop the write.
    acc(1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, st, rd, rv, er);
    @(negedge clk);
    wen = 1'b1; addr = 32'h40; wdata = 32'h77; wstrb = 4'hF;
    @(posedge clk);
    #1;
    check("busy_stall", 32'(stall), 32'd1);
    wen = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_stall",  32'(stall),  32'd0);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_rdata",  rdata,       32'd0);
    check("midrst_err",    32'(err),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    acc(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, st, rd, rv, er);
    check("rd40_after_rst", rd, 32'h12345678);

    acc(1'b0, 1'b1, 32'h42, 32'h99, 4'hF, st, rd, rv, er);
`ifdef DMEM_ERR_EN
    check("wr42_err", 32'(er), 32'd1);
`else
    check("wr42_err", 32'(er), 32'd0);
`endif
    check("wr42_err_pulse", 32'(err), 32'd0);
    acc(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, st, rd, rv, er);
`ifdef DMEM_ERR_EN
    check("rd40_after_42", rd, 32'h12345678);
`else
    check("rd40_after_42", rd, 32'h00000099);
`endif
    check("rd40_err", 32'(er), 32'd0);

    acc(1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, st, rd, rv, er);
    check("rdhi_rvalid", 32'(rv), 32'd1);
`ifdef DMEM_ERR_EN
    check("rdhi_rdata", rd, 32'h0);
    check("rdhi_err",   32'(er), 32'd1);
`else
    check("rdhi_rdata", rd, 32'hDEADBEEF);
    check("rdhi_err",   32'(er), 32'd0);
`endif

    // Single-cycle instance.
    @(negedge clk);
    wen0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hCAFEF00D; wstrb0 = 4'hF;
    #1;
    check("l0_wr_rvalid", 32'(rvalid0), 32'd0);
    @(negedge clk);
    wen0 = 1'b0; ren0 = 1'b1;
    #1;
    check("l0_rd_rdata",  rdata0,        32'hCAFEF00D);
    check("l0_rd_rvalid", 32'(rvalid0),  32'd1);
    @(negedge clk);
    ren0 = 1'b0; wen0 = 1'b1; wdata0 = 32'hFFFFFFFF; wstrb0 = 4'b0010;
    @(negedge clk);
    wen0 = 1'b0; ren0 = 1'b1;
    #1;
    check("l0_strb_rdata", rdata0, 32'hCAFEFF0D);
    @(negedge clk);
    ren0 = 1'b1; wen0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h5; wstrb0 = 4'hF;
    #1;
    check("l0_rw_rvalid", 32'(rvalid0), 32'd0);
    @(negedge clk);
    wen0 = 1'b0;
    #1;
    check("l0_rd30_rdata", rdata0, 32'h5);
    check("l0_err",        32'(err0), 32'd0);
    @(negedge clk);
    ren0 = 1'b0;
    check("l0_no_stall", 32'(stall0_hits), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lat.md
# dmem_lat

Parametrised data-memory model for the RVCORE core's data port. It extends the single-cycle `dmem` with configurable width, depth and access latency, per-byte write strobes, and a stall handshake. It sits between the core's `o_memaddr`/`o_write_*`/`o_read_en`/`i_read_data` pins and drives the core's `i_exstall`, so benches can exercise pipeline stall paths against a slow memory.

## Interface
- `DWIDTH`, default 32: data word width in bits; a multiple of 8.
- `AWIDTH`, default 32: byte-address width.
- `DEPTH`, default 1024: number of words; a power of two.
- `LATENCY`, default 2: stall cycles per access; 0 selects single-cycle mode.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_ren`  in  1  read request.
- `i_wen`  in  1  write request.
- `i_addr`  in  AWIDTH  byte address.
- `i_wdata`  in  DWIDTH  write data.
- `i_wstrb`  in  DWIDTH/8  byte-lane write enables.
- `o_rdata`  out  DWIDTH  read data.
- `o_rvalid`  out  1  read data valid this cycle.
- `o_stall`  out  1  stall request to the core (`i_exstall`).
- `o_err`  out  1  access error pulse (see Configuration).

## Operation
- Storage is `DEPTH` words of `DWIDTH` bits. Word index is `i_addr[OFS +: log2(DEPTH)]`, where OFS = log2(DWIDTH/8). Memory contents are not reset.
- A request is `i_ren | i_wen`. If both are set, the access is a write; `o_rvalid` stays low and `o_rdata` is unchanged.
- Writes update only lanes with `i_wstrb[k]=1`. Other lanes keep their old value.
- LATENCY=0:
  - No FSM; `o_stall` is always 0.
  - Write commits at the rising edge.
  - `o_rdata` is combinational from the array at the current word index.
  - `o_rvalid = i_ren & ~i_wen`.
- LATENCY≥1 FSM, states IDLE, BUSY, DONE:
  - IDLE: a request sets `o_stall=1` combinationally. Address, data, strobe and type are latched. Counter loads LATENCY-1. Next state is BUSY if LATENCY>1, else DONE.
  - BUSY: `o_stall=1`. Counter decrements each cycle; at 0 the next state is DONE.
  - DONE: `o_stall=0`.
    - Read: `o_rdata` is the registered word and `o_rvalid=1` for this cycle only.
    - Write: commits at the edge ending DONE.
    - Inputs are ignored in DONE, because the core still presents the stalled request. Next state is always IDLE.
- `o_rdata` holds the last completed read value until the next read completes.
- Read-after-write to the same address, back-to-back, returns the new data.

## Timing
- Reset values: state IDLE, counter 0, `o_rdata=0`, `o_rvalid=0`, `o_err=0`. `o_stall` equals its combinational IDLE term, so it is 0 with no request present.
- With LATENCY=L≥1, an access accepted in cycle 0 stalls cycles 0..L-1 and completes in cycle L. Throughput is one access per L+1 cycles; the next request can be accepted in cycle L+1.
- Reset asserted mid-access returns the FSM to IDLE immediately. A pending write is dropped and memory is unchanged.
- Counter width is ceil(log2(LATENCY))+1 bits and never underflows.

## Configuration
- `DMEM_ERR_EN` defined:
  - An access whose `i_addr[OFS-1:0]≠0`, or whose bits above the index field are nonzero, is erroneous.
  - `o_err` pulses for one cycle in the completion cycle: DONE, or the access cycle when LATENCY=0.
  - An erroneous write is suppressed.
  - An erroneous read returns `o_rdata=0` with `o_rvalid=1`.
- `DMEM_ERR_EN` undefined: `o_err` is tied to 0, offset bits are ignored, and upper address bits wrap modulo DEPTH.

## Test plan
- LATENCY=2, write 0xDEADBEEF to 0x10 with strobe 0xF, then read 0x10:
  - `o_stall` is high for exactly 2 cycles per access.
  - The read's DONE cycle shows `o_rvalid=1` and `o_rdata=0xDEADBEEF`.
- Byte strobe: after the word at 0x20 holds 0x11223344, a write of 0xAABBCCDD with strobe 0b0101 makes a read return 0x11BB33DD.
- LATENCY=0: a read of 0x10 returns data the same cycle and `o_stall` never asserts.
- Simultaneous `i_ren=i_wen=1` at 0x30 with data 0x5 → treated as a write, `o_rvalid=0`, and a later read returns 0x5.
- Reset pulled low during BUSY of a write of 0x77 to 0x40 → state IDLE, all outputs 0, and a read of 0x40 returns the prior value.
- With `DMEM_ERR_EN`:
  - A write to 0x42 raises a 1-cycle `o_err` and memory is unchanged.
  - Without the macro, the same write lands at word index 0x10.
